axi_dw_beat_sequencer: RTL and testbench

Control sequencer for the AXI data-width downsizer datapath. It accepts one wide-side (slave-port) burst descriptor at a time and emits the ordered stream of narrow-side (master-port) beats: address, lane select within the wide word, and wide-beat/burst boundary flags. The downsizer datapath uses these beats to steer its R/W lane muxes and to pack or unpack data. It sits between the AR/AW decode stage and the lane-steering datapath, one instance per direction.

---
 rtl/axi_dw_seq_pkg.sv | 36 +++
 rtl/axi_dw_seq_addr_gen.sv | 56 +++++
 rtl/axi_dw_beat_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_axi_dw_beat_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_dw_seq_pkg.sv
// -----------------------------------------------------------------------------
// axi_dw_seq_pkg
// Shared definitions for the AXI data-width downsizer beat sequencer:
//   - AXI burst encodings
//   - sequencer state enum
//   - narrow_per_wide(): narrow beats needed to cover one AXI transfer
//   - wrap_supported_len(): legal WRAP lengths (2, 4, 8, 16 beats)
// No ports (package).
// -----------------------------------------------------------------------------
package axi_dw_seq_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2
  } seq_state_e;

  // A transfer of 2^size bytes needs 2^size/mst_bytes narrow beats, but never
  // fewer than one (sub-narrow transfers still occupy a full narrow beat).
  function automatic int unsigned narrow_per_wide(input logic [2:0] size,
                                                  input int unsigned mst_bytes);
    int unsigned cont;
    cont = 32'd1 << size;
    if (cont > mst_bytes) return cont / mst_bytes;
    return 1;
  endfunction

  function automatic logic wrap_supported_len(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_dw_seq_addr_gen.sv
// -----------------------------------------------------------------------------
// axi_dw_seq_addr_gen
// Combinational next-address generator for the downsizer beat sequencer.
// Optional feature macro: AXI_DW_SEQ_WRAP_EN (adds WRAP boundary handling).
// Ports:
//   cur_addr_i     current narrow beat address
//   base_addr_i    base of the current 2^size container
//   start_addr_i   burst start address (FIXED return point)
//   size_i         AXI size of the burst
//   burst_i        AXI burst type
//   wrap_lo_i/_hi_i  lower/upper wrap boundary (only with AXI_DW_SEQ_WRAP_EN)
//   next_narrow_o  next address inside the same container
//   next_wide_o    first address of the next container
// -----------------------------------------------------------------------------
module axi_dw_seq_addr_gen
  import axi_dw_seq_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned MstBytes  = 2
) (
  input  logic [AddrWidth-1:0] cur_addr_i,
  input  logic [AddrWidth-1:0] base_addr_i,
  input  logic [AddrWidth-1:0] start_addr_i,
  input  logic [2:0]           size_i,
  input  logic [1:0]           burst_i,
`ifdef AXI_DW_SEQ_WRAP_EN
  input  logic [AddrWidth-1:0] wrap_lo_i,
  input  logic [AddrWidth-1:0] wrap_hi_i,
`endif
  output logic [AddrWidth-1:0] next_narrow_o,
  output logic [AddrWidth-1:0] next_wide_o
);

  logic [AddrWidth-1:0] mst_mask;
  logic [AddrWidth-1:0] cont;
  logic [AddrWidth-1:0] incr_addr;

  assign mst_mask      = ~AddrWidth'(MstBytes - 1);
  assign cont          = AddrWidth'(1) << size_i;
  // An unaligned first beat is pulled onto the narrow grid by the next step.
  assign next_narrow_o = (cur_addr_i & mst_mask) + AddrWidth'(MstBytes);
  assign incr_addr     = base_addr_i + cont;

  always_comb begin
    next_wide_o = incr_addr;
    case (burst_i)
      BURST_FIXED: next_wide_o = start_addr_i & mst_mask;
`ifdef AXI_DW_SEQ_WRAP_EN
      // Only whole containers wrap; the narrow path never crosses wrap_hi.
      BURST_WRAP:  next_wide_o = (incr_addr == wrap_hi_i) ? wrap_lo_i : incr_addr;
`endif
      default:     next_wide_o = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi_dw_beat_sequencer.sv
// -----------------------------------------------------------------------------
// axi_dw_beat_sequencer
// Turns one wide-side AXI burst descriptor into the ordered stream of narrow
// beats (address, lane, wide-beat/burst last flags) for the downsizer datapath.
// Optional feature macro: AXI_DW_SEQ_WRAP_EN (WRAP bursts; otherwise WRAP is
// answered with a single error beat).
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o      descriptor handshake
//   cmd_addr_i/len_i/size_i/burst_i  descriptor fields (sampled on handshake)
//   beat_valid_o/beat_ready_i    narrow beat handshake
//   beat_addr_o, beat_lane_o     narrow address and lane inside the wide word
//   beat_wide_last_o, beat_last_o  end of wide beat / end of burst
//   beat_err_o                   unsupported descriptor (single beat)
//   dbg_state_o                  current FSM state (seq_state_e encoding)
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. A producer holds valid and its payload stable until that
// edge; ready may depend combinationally on the other side's signals.
// -----------------------------------------------------------------------------
module axi_dw_beat_sequencer
  import axi_dw_seq_pkg::*;
#(
  parameter  int unsigned SlvDataWidth = 64,
  parameter  int unsigned MstDataWidth = 16,
  parameter  int unsigned AddrWidth    = 32,
  localparam int unsigned SlvBytes     = SlvDataWidth / 8,
  localparam int unsigned MstBytes     = MstDataWidth / 8,
  localparam int unsigned LaneW        = $clog2(SlvBytes / MstBytes)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [AddrWidth-1:0] cmd_addr_i,
  input  logic [7:0]           cmd_len_i,
  input  logic [2:0]           cmd_size_i,
  input  logic [1:0]           cmd_burst_i,
  output logic                 beat_valid_o,
  input  logic                 beat_ready_i,
  output logic [AddrWidth-1:0] beat_addr_o,
  output logic [LaneW-1:0]     beat_lane_o,
  output logic                 beat_wide_last_o,
  output logic                 beat_last_o,
  output logic                 beat_err_o,
  output logic [1:0]           dbg_state_o
);

  localparam int unsigned SlvSizeMax = $clog2(SlvBytes);
  localparam int unsigned MstOff     = $clog2(MstBytes);
  localparam int unsigned NpwW       = LaneW + 1;

  seq_state_e           state_q;
  logic                 valid_q, wide_last_q, last_q, err_q;
  logic [AddrWidth-1:0] addr_q, start_q;
  logic [2:0]           size_q;
  logic [1:0]           burst_q;
  logic [7:0]           wide_cnt_q;  // wide beats still to start after this one
  logic [NpwW-1:0]      nar_cnt_q;   // narrow beats left after this one in the wide beat
  logic [NpwW-1:0]      npw_q;       // narrow beats in a full container
`ifdef AXI_DW_SEQ_WRAP_EN
  logic [AddrWidth-1:0] wrap_lo_q, wrap_hi_q;
  logic [AddrWidth-1:0] cmd_wrap_bytes, cmd_wrap_lo;
`endif

  logic                 cmd_hs, beat_hs, cmd_err;
  logic [AddrWidth-1:0] cmd_cont, cmd_off;
  logic [NpwW-1:0]      cmd_npw, cmd_skip, cmd_nar;
  logic [AddrWidth-1:0] cur_cont, cur_base, nxt_narrow, nxt_wide;

  assign cmd_ready_o = ~rst_i & ((state_q == ST_IDLE) | (valid_q & beat_ready_i & last_q));
  assign cmd_hs      = cmd_valid_i & cmd_ready_o;
  assign beat_hs     = valid_q & beat_ready_i;

  // First wide beat starts at the narrow slot holding cmd_addr_i.
  assign cmd_cont = AddrWidth'(1) << cmd_size_i;
  assign cmd_off  = cmd_addr_i & (cmd_cont - AddrWidth'(1));
  assign cmd_skip = NpwW'(cmd_off >> MstOff);
  assign cmd_npw  = NpwW'(narrow_per_wide(cmd_size_i, MstBytes));
  assign cmd_nar  = cmd_npw - NpwW'(1) - cmd_skip;

`ifdef AXI_DW_SEQ_WRAP_EN
  assign cmd_wrap_bytes = AddrWidth'({1'b0, cmd_len_i} + 9'd1) << cmd_size_i;
  assign cmd_wrap_lo    = cmd_addr_i & ~(cmd_wrap_bytes - AddrWidth'(1));
`endif

  always_comb begin
    cmd_err = 1'b0;
    if (cmd_size_i > 3'(SlvSizeMax)) cmd_err = 1'b1;
    if ((cmd_burst_i == BURST_FIXED) && (cmd_len_i != 8'd0)) cmd_err = 1'b1;
    if (cmd_burst_i == BURST_WRAP) begin
`ifdef AXI_DW_SEQ_WRAP_EN
      if (!wrap_supported_len(cmd_len_i)) cmd_err = 1'b1;
`else
      cmd_err = 1'b1;
`endif
    end
  end

  assign cur_cont = AddrWidth'(1) << size_q;
  assign cur_base = addr_q & ~(cur_cont - AddrWidth'(1));

  axi_dw_seq_addr_gen #(
    .AddrWidth (AddrWidth),
    .MstBytes  (MstBytes)
  ) u_addr_gen (
    .cur_addr_i    (addr_q),
    .base_addr_i   (cur_base),
    .start_addr_i  (start_q),
    .size_i        (size_q),
    .burst_i       (burst_q),
`ifdef AXI_DW_SEQ_WRAP_EN
    .wrap_lo_i     (wrap_lo_q),
    .wrap_hi_i     (wrap_hi_q),
`endif
    .next_narrow_o (nxt_narrow),
    .next_wide_o   (nxt_wide)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      valid_q     <= 1'b0;
      wide_last_q <= 1'b0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      start_q     <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      wide_cnt_q  <= '0;
      nar_cnt_q   <= '0;
      npw_q       <= '0;
`ifdef AXI_DW_SEQ_WRAP_EN
      wrap_lo_q   <= '0;
      wrap_hi_q   <= '0;
`endif
    end else if (cmd_hs) begin
      // Also covers a new command accepted on the previous burst's last beat.
      valid_q <= 1'b1;
      addr_q  <= cmd_addr_i;
      start_q <= cmd_addr_i;
      size_q  <= cmd_size_i;
      burst_q <= cmd_burst_i;
      npw_q   <= cmd_npw;
`ifdef AXI_DW_SEQ_WRAP_EN
      wrap_lo_q <= cmd_wrap_lo;
      wrap_hi_q <= cmd_wrap_lo + cmd_wrap_bytes;
`endif
      if (cmd_err) begin
        state_q     <= ST_ERR;
        err_q       <= 1'b1;
        wide_last_q <= 1'b1;
        last_q      <= 1'b1;
        wide_cnt_q  <= '0;
        nar_cnt_q   <= '0;
      end else begin
        state_q     <= ST_BUSY;
        err_q       <= 1'b0;
        wide_cnt_q  <= cmd_len_i;
        nar_cnt_q   <= cmd_nar;
        wide_last_q <= (cmd_nar == '0);
        last_q      <= (cmd_nar == '0) && (cmd_len_i == 8'd0);
      end
    end else if (beat_hs) begin
      if (last_q) begin
        state_q     <= ST_IDLE;
        valid_q     <= 1'b0;
        err_q       <= 1'b0;
        wide_last_q <= 1'b0;
        last_q      <= 1'b0;
      end else if (wide_last_q) begin
        wide_cnt_q  <= wide_cnt_q - 8'd1;
        nar_cnt_q   <= npw_q - NpwW'(1);
        addr_q      <= nxt_wide;
        wide_last_q <= (npw_q == NpwW'(1));
        last_q      <= (wide_cnt_q == 8'd1) && (npw_q == NpwW'(1));
      end else begin
        nar_cnt_q   <= nar_cnt_q - NpwW'(1);
        addr_q      <= nxt_narrow;
        wide_last_q <= (nar_cnt_q == NpwW'(1));
        last_q      <= (wide_cnt_q == 8'd0) && (nar_cnt_q == NpwW'(1));
      end
    end
  end

  assign beat_valid_o     = valid_q;
  assign beat_addr_o      = addr_q;
  assign beat_lane_o      = addr_q[SlvSizeMax-1:MstOff];
  assign beat_wide_last_o = wide_last_q;
  assign beat_last_o      = last_q;
  assign beat_err_o       = err_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_axi_dw_beat_sequencer.sv
// -----------------------------------------------------------------------------
// tb_axi_dw_beat_sequencer
// Bench for axi_dw_beat_sequencer (SlvDataWidth=64, MstDataWidth=16).
// Expected beats come from a container-level model of the burst rules.
// Honours AXI_DW_SEQ_WRAP_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_axi_dw_beat_sequencer;

  localparam int unsigned MST = 2;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [31:0] cmd_addr_i;
  logic [7:0]  cmd_len_i;
  logic [2:0]  cmd_size_i;
  logic [1:0]  cmd_burst_i;
  logic        beat_valid_o;
  logic        beat_ready_i;
  logic [31:0] beat_addr_o;
  logic [1:0]  beat_lane_o;
  logic        beat_wide_last_o;
  logic        beat_last_o;
  logic        beat_err_o;
  logic [1:0]  dbg_state_o;

  always #5 clk = ~clk;

  axi_dw_beat_sequencer #(
    .SlvDataWidth (64),
    .MstDataWidth (16),
    .AddrWidth    (32)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .cmd_valid_i      (cmd_valid_i),
    .cmd_ready_o      (cmd_ready_o),
    .cmd_addr_i       (cmd_addr_i),
    .cmd_len_i        (cmd_len_i),
    .cmd_size_i       (cmd_size_i),
    .cmd_burst_i      (cmd_burst_i),
    .beat_valid_o     (beat_valid_o),
    .beat_ready_i     (beat_ready_i),
    .beat_addr_o      (beat_addr_o),
    .beat_lane_o      (beat_lane_o),
    .beat_wide_last_o (beat_wide_last_o),
    .beat_last_o      (beat_last_o),
    .beat_err_o       (beat_err_o),
    .dbg_state_o      (dbg_state_o)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } cmd_t;

  cmd_t        cmd_q[$];
  // Beat vector: {err, last, wide_last, lane[1:0], addr[31:0]}
  logic [36:0] exp_q[$];
  int          total_cnt = 0;
  int          pass_cnt  = 0;
  int          b2b_cnt   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic add_cmd(input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    cmd_t c;
    c.addr = addr; c.len = len; c.size = size; c.burst = burst;
    cmd_q.push_back(c);
  endtask

  // Reference: enumerate the burst container by container, then the narrow
  // slots inside each container, skipping slots below the start address.
  task automatic push_model(input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] cont, c0, c, wbytes, lo, a;
    int unsigned slots, first_slot;
    bit err;
    cont = 32'd1 << size;
    err  = (size > 3) || (burst == 2'd0 && len != 0);
    if (burst == 2'd2) begin
`ifdef AXI_DW_SEQ_WRAP_EN
      if (!(len == 1 || len == 3 || len == 7 || len == 15)) err = 1;
`else
      err = 1;
`endif
    end
    if (err) begin
      exp_q.push_back({1'b1, 1'b1, 1'b1, addr[2:1], addr});
      return;
    end
    c0     = addr & ~(cont - 1);
    wbytes = ({24'd0, len} + 32'd1) * cont;
    lo     = addr & ~(wbytes - 1);
    slots  = (cont > MST) ? cont / MST : 1;
    for (int i = 0; i <= int'(len); i++) begin
      if (burst == 2'd2)      c = lo + ((c0 - lo) + i * cont) % wbytes;
      else if (burst == 2'd0) c = c0;
      else                    c = c0 + i * cont;
      first_slot = (i == 0) ? (addr - c) / MST : 0;
      for (int k = first_slot; k < int'(slots); k++) begin
        a = (i == 0 && k == int'(first_slot)) ? addr : c + k * MST;
        exp_q.push_back({1'b0, (k == int'(slots) - 1) && (i == int'(len)),
                         k == int'(slots) - 1, a[2:1], a});
      end
    end
  endtask

  task automatic present_next();
    cmd_t c;
    if (cmd_q.size() > 0) begin
      c = cmd_q.pop_front();
      cmd_valid_i = 1'b1;
      cmd_addr_i  = c.addr;
      cmd_len_i   = c.len;
      cmd_size_i  = c.size;
      cmd_burst_i = c.burst;
    end else begin
      // Junk on idle fields must be ignored.
      cmd_valid_i = 1'b0;
      cmd_addr_i  = $urandom();
      cmd_len_i   = 8'($urandom());
      cmd_size_i  = 3'($urandom());
      cmd_burst_i = 2'($urandom());
    end
  endtask

  // Drives queued commands and checks every cycle until all beats drain.
  // beat_ready_i is held low for stall_cycles, then high with pct% chance.
  task automatic run_cmds(input int pct, input int stall_cycles, input int max_cycles);
    bit accepted = 1'b1;
    bit done = 1'b0;
    logic exp_rdy;
    for (int cyc = 0; cyc < max_cycles; cyc++) begin
      @(negedge clk);
      if (accepted) begin present_next(); accepted = 1'b0; end
      beat_ready_i = (cyc < stall_cycles) ? 1'b0 : ($urandom_range(0, 99) < pct);
      #1;
      exp_rdy = (exp_q.size() == 0) || (beat_ready_i && exp_q[0][35]);
      chk("cmd_ready", cmd_ready_o, exp_rdy);
      if (exp_q.size() > 0) begin
        chk("beat_valid", beat_valid_o, 1'b1);
        if (beat_valid_o) begin
          chk("beat", {beat_err_o, beat_last_o, beat_wide_last_o, beat_lane_o, beat_addr_o},
              exp_q[0]);
          if (beat_ready_i) void'(exp_q.pop_front());
        end
      end else begin
        chk("beat_idle", beat_valid_o, 1'b0);
      end
      if (cmd_valid_i && cmd_ready_o) begin
        if (beat_valid_o && beat_ready_i && beat_last_o) b2b_cnt++;
        push_model(cmd_addr_i, cmd_len_i, cmd_size_i, cmd_burst_i);
        accepted = 1'b1;
      end
      if (!cmd_valid_i && cmd_q.size() == 0 && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain_within_budget", done, 1'b1);
    cmd_q.delete();
    exp_q.delete();
    cmd_valid_i = 1'b0;
  endtask

  initial begin
    int b2b_before;
    logic [1:0] rb;
    logic [7:0] rl;
    logic [31:0] ra;
    rst_i = 1'b1;
    cmd_valid_i = 1'b0; cmd_addr_i = '0; cmd_len_i = '0; cmd_size_i = '0; cmd_burst_i = '0;
    beat_ready_i = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready_o, 1'b0);
    chk("rst_outputs", {beat_valid_o, beat_err_o, beat_last_o, beat_wide_last_o, beat_lane_o, beat_addr_o}, '0);
    chk("rst_state_idle", dbg_state_o, 2'd0);
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    chk("idle_cmd_ready", cmd_ready_o, 1'b1);

    // Directed bursts from the feature list.
    add_cmd(32'h100, 8'd1, 3'd3, 2'd1); run_cmds(100, 0, 200);
    add_cmd(32'h103, 8'd0, 3'd3, 2'd1); run_cmds(100, 0, 200);
    add_cmd(32'h010, 8'd3, 3'd1, 2'd1); run_cmds(100, 0, 200);
    add_cmd(32'h040, 8'd0, 3'd3, 2'd0); run_cmds(100, 0, 200);
    add_cmd(32'h040, 8'd2, 3'd3, 2'd0); run_cmds(100, 0, 200);
    add_cmd(32'h040, 8'd0, 3'd4, 2'd1); run_cmds(100, 0, 200);
    add_cmd(32'h018, 8'd1, 3'd3, 2'd2); run_cmds(100, 0, 200);
    add_cmd(32'h018, 8'd2, 3'd3, 2'd2); run_cmds(100, 0, 200);
    add_cmd(32'hFFFF_FFFC, 8'd1, 3'd2, 2'd1); run_cmds(100, 0, 200);

    // Backpressure: first beat held for several cycles.
    add_cmd(32'h300, 8'd1, 3'd3, 2'd1); run_cmds(100, 5, 200);

    // Back-to-back: second command waits and is taken on the last beat.
    b2b_before = b2b_cnt;
    add_cmd(32'h400, 8'd0, 3'd3, 2'd1);
    add_cmd(32'h500, 8'd1, 3'd2, 2'd1);
    add_cmd(32'h600, 8'd0, 3'd5, 2'd1);
    run_cmds(100, 0, 200);
    chk("b2b_accept_on_last", b2b_cnt - b2b_before, 2);

    // Reset in the middle of a burst.
    @(negedge clk);
    cmd_valid_i = 1'b1; cmd_addr_i = 32'h200; cmd_len_i = 8'd3; cmd_size_i = 3'd3; cmd_burst_i = 2'd1;
    beat_ready_i = 1'b1;
    #1;
    chk("mid_rst_accept", cmd_ready_o, 1'b1);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    #1;
    chk("mid_rst_beat0", {beat_valid_o, beat_addr_o}, {1'b1, 32'h200});
    @(negedge clk);
    #1;
    chk("mid_rst_beat1", {beat_valid_o, beat_addr_o}, {1'b1, 32'h202});
    @(negedge clk);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_ready_low", cmd_ready_o, 1'b0);
    @(negedge clk);
    #1;
    chk("mid_rst_valid_low", beat_valid_o, 1'b0);
    rst_i = 1'b0;
    #1;
    chk("post_rst_ready", cmd_ready_o, 1'b1);
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("post_rst_no_beats", beat_valid_o, 1'b0);
    end

    // Randomised bursts with random backpressure, queued back to back.
    for (int n = 0; n < 40; n++) begin
      rb = 2'($urandom_range(0, 2));
      ra = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255)))
                                       : 32'($urandom_range(0, 16'hFFFF));
      case (rb)
        2'd0:    rl = ($urandom_range(0, 4) == 0) ? 8'd2 : 8'd0;
        2'd2: begin
          case ($urandom_range(0, 4))
            0: rl = 8'd1;
            1: rl = 8'd3;
            2: rl = 8'd7;
            3: rl = 8'd15;
            default: rl = 8'd2;
          endcase
        end
        default: rl = 8'($urandom_range(0, 15));
      endcase
      add_cmd(ra, rl, 3'($urandom_range(0, 4)), rb);
    end
    run_cmds(70, 0, 20000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
